// File: rtl/local_ale_pkg.sv
// Shared widths, weight default and pixel type for the local atmospheric-light estimator.
package local_ale_pkg;

   localparam int unsigned PIX_W          = 8;
   localparam int unsigned W_W            = 9;
   localparam int unsigned PROD_W         = 17;
   localparam int unsigned LAMBDA_DEFAULT = 128;
   localparam int unsigned W_ONE          = 256;

   typedef logic [PIX_W-1:0] pix_t;

endpackage : local_ale_pkg

// File: rtl/local_ale_if.sv
// Pixel-side bundle: dark-channel value and global light in, local light out.
interface local_ale_if;
   import local_ale_pkg::*;

   pix_t d;
   pix_t ar_g;
   pix_t ag_g;
   pix_t ab_g;
   pix_t ar_l;
   pix_t ag_l;
   pix_t ab_l;

   modport master (output d, ar_g, ag_g, ab_g, input  ar_l, ag_l, ab_l);
   modport slave  (input  d, ar_g, ag_g, ab_g, output ar_l, ag_l, ab_l);

endinterface : local_ale_if

// File: rtl/ale_channel.sv
// One colour channel: clip D against the global light, then blend the two with weight LAMBDA.
module ale_channel
   import local_ale_pkg::*;
#(
   parameter int unsigned LAMBDA = LAMBDA_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  pix_t d_i,
   input  pix_t a_global_i,
   output pix_t a_local_o
);

   localparam logic [W_W-1:0] LAM_W = W_W'(LAMBDA);
   localparam logic [W_W-1:0] INV_W = W_W'(W_ONE - LAMBDA);

   pix_t              m_d, m_q;
   pix_t              a_q;
   pix_t              local_d, local_q;
   logic [PROD_W-1:0] prod_a;
   logic [PROD_W-1:0] prod_m;
   logic [PROD_W-1:0] sum;

   // Stage 1 input: the clipped dark-channel term
   always_comb begin
      m_d = a_global_i;
      if (d_i < a_global_i) begin
         m_d = d_i;
      end
   end

   // Stage 2 input: weights sum to 256, so the blend never exceeds a_q and needs no saturation
   always_comb begin
      prod_a  = PROD_W'(INV_W) * PROD_W'(a_q);
      prod_m  = PROD_W'(LAM_W) * PROD_W'(m_q);
      sum     = prod_a + prod_m;
      local_d = PIX_W'(sum >> PIX_W);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_q     <= '0;
         a_q     <= '0;
         local_q <= '0;
      end else begin
         m_q     <= m_d;
         a_q     <= a_global_i;
         local_q <= local_d;
      end
   end

   assign a_local_o = local_q;

endmodule : ale_channel

// File: rtl/local_ale.sv
// Local atmospheric light: three independent lockstep channel pipelines, latency 2, one pixel per clock.
module local_ale
   import local_ale_pkg::*;
#(
   parameter int unsigned LAMBDA = LAMBDA_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  pix_t IDark_dash,
   input  pix_t AR_global,
   input  pix_t AG_global,
   input  pix_t AB_global,
   output pix_t AR_local,
   output pix_t AG_local,
   output pix_t AB_local
);

   ale_channel #(.LAMBDA(LAMBDA)) u_ch_r (
      .clk        (clk),
      .rst        (rst),
      .d_i        (IDark_dash),
      .a_global_i (AR_global),
      .a_local_o  (AR_local)
   );

   ale_channel #(.LAMBDA(LAMBDA)) u_ch_g (
      .clk        (clk),
      .rst        (rst),
      .d_i        (IDark_dash),
      .a_global_i (AG_global),
      .a_local_o  (AG_local)
   );

   ale_channel #(.LAMBDA(LAMBDA)) u_ch_b (
      .clk        (clk),
      .rst        (rst),
      .d_i        (IDark_dash),
      .a_global_i (AB_global),
      .a_local_o  (AB_local)
   );

endmodule : local_ale

// File: tb/tb_local_ale.sv
// Directed and random checks of local_ale at weights 128, 0, 256 and 77 fed from one shared stimulus.
module tb_local_ale;
   import local_ale_pkg::*;

   typedef logic [2:0][7:0]       rgb_t;
   typedef logic [3:0][2:0][7:0]  exp_t;

   localparam int unsigned LAMS [4] = '{128, 0, 256, 77};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #10 clk = ~clk;

   local_ale_if bus ();

   rgb_t o1, o2, o3;
   wire  exp_t act = {o3, o2, o1, {bus.ab_l, bus.ag_l, bus.ar_l}};

   local_ale #(.LAMBDA(128)) u_dut (
      .clk (clk), .rst (rst), .IDark_dash (bus.d),
      .AR_global (bus.ar_g), .AG_global (bus.ag_g), .AB_global (bus.ab_g),
      .AR_local (bus.ar_l), .AG_local (bus.ag_l), .AB_local (bus.ab_l)
   );
   local_ale #(.LAMBDA(0)) u_dut_l0 (
      .clk (clk), .rst (rst), .IDark_dash (bus.d),
      .AR_global (bus.ar_g), .AG_global (bus.ag_g), .AB_global (bus.ab_g),
      .AR_local (o1[0]), .AG_local (o1[1]), .AB_local (o1[2])
   );
   local_ale #(.LAMBDA(256)) u_dut_l256 (
      .clk (clk), .rst (rst), .IDark_dash (bus.d),
      .AR_global (bus.ar_g), .AG_global (bus.ag_g), .AB_global (bus.ab_g),
      .AR_local (o2[0]), .AG_local (o2[1]), .AB_local (o2[2])
   );
   local_ale #(.LAMBDA(77)) u_dut_l77 (
      .clk (clk), .rst (rst), .IDark_dash (bus.d),
      .AR_global (bus.ar_g), .AG_global (bus.ag_g), .AB_global (bus.ab_g),
      .AR_local (o3[0]), .AG_local (o3[1]), .AB_local (o3[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   function automatic rgb_t rgb(input pix_t r, input pix_t g, input pix_t b);
      return {b, g, r};
   endfunction

   function automatic exp_t ex3(input rgb_t l128, input rgb_t l0, input rgb_t l256);
      return {24'd0, l256, l0, l128};
   endfunction

   function automatic pix_t ref_ale(input int unsigned l, input pix_t d, input pix_t a);
      int unsigned m;
      m = (d < a) ? 32'(d) : 32'(a);
      return pix_t'(((256 - l) * 32'(a) + l * m) / 256);
   endfunction

   // Two-deep expectation line mirroring the pipeline latency
   exp_t       e1 = '0, e2 = '0;
   logic [3:0] m1 = '0, m2 = '0;
   rgb_t       a1 = '0, a2 = '0;

   task automatic apply(input logic r, input pix_t d, input rgb_t a,
                        input logic [3:0] mask, input exp_t e);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         if (m2[i]) begin
            for (int c = 0; c < 3; c++) begin
               check($sformatf("L%0d_ch%0d", LAMS[i], c), 32'(act[i][c]), 32'(e2[i][c]));
               check($sformatf("bound_L%0d_ch%0d", LAMS[i], c), 32'(act[i][c] <= a2[c]), 32'd1);
            end
         end
      end
      e2 = e1; m2 = m1; a2 = a1;
      e1 = e;  m1 = mask; a1 = a;
      if (r) begin
         e2 = '0; m2 = '1;
         e1 = '0; m1 = '1;
      end
      rst      = r;
      bus.d    = d;
      bus.ar_g = a[0];
      bus.ag_g = a[1];
      bus.ab_g = a[2];
   endtask

   initial begin
      rgb_t a_nom;
      rgb_t a_ext;
      a_nom = rgb(8'd120, 8'd140, 8'd160);
      a_ext = rgb(8'd200, 8'd10, 8'd255);
      bus.d = 8'd0; bus.ar_g = 8'd0; bus.ag_g = 8'd0; bus.ab_g = 8'd0;

      // Reset held two edges with live inputs, then constant nominal inputs
      apply(1'b1, 8'd200, rgb(8'd1, 8'd2, 8'd3), 4'b0000, '0);
      apply(1'b1, 8'd200, rgb(8'd1, 8'd2, 8'd3), 4'b0000, '0);
      for (int k = 0; k < 3; k++)
         apply(1'b0, 8'd150, a_nom, 4'b0001, ex3(rgb(8'd120, 8'd140, 8'd155), '0, '0));

      // D stream against fixed global light
      apply(1'b0, 8'd100, a_nom, 4'b0001, ex3(rgb(8'd110, 8'd120, 8'd130), '0, '0));
      apply(1'b0, 8'd180, a_nom, 4'b0001, ex3(rgb(8'd120, 8'd140, 8'd160), '0, '0));
      apply(1'b0, 8'd60,  a_nom, 4'b0001, ex3(rgb(8'd90,  8'd100, 8'd110), '0, '0));
      apply(1'b0, 8'd80,  a_nom, 4'b0001, ex3(rgb(8'd100, 8'd110, 8'd120), '0, '0));

      // Weight and pixel extremes
      apply(1'b0, 8'd50, a_ext, 4'b0111,
            ex3(rgb(8'd125, 8'd10, 8'd152), a_ext, rgb(8'd50, 8'd10, 8'd50)));
      apply(1'b0, 8'd255, rgb(8'd255, 8'd255, 8'd255), 4'b0111,
            ex3(rgb(8'd255, 8'd255, 8'd255), rgb(8'd255, 8'd255, 8'd255), rgb(8'd255, 8'd255, 8'd255)));
      apply(1'b0, 8'd0, rgb(8'd255, 8'd1, 8'd0), 4'b0111,
            ex3(rgb(8'd127, 8'd0, 8'd0), rgb(8'd255, 8'd1, 8'd0), rgb(8'd0, 8'd0, 8'd0)));

      // Reset pulse between two valid inputs flushes both in-flight slots
      apply(1'b0, 8'd100, a_nom, 4'b0001, ex3(rgb(8'd110, 8'd120, 8'd130), '0, '0));
      apply(1'b1, 8'd180, a_nom, 4'b0000, '0);
      apply(1'b0, 8'd60,  a_nom, 4'b0001, ex3(rgb(8'd90,  8'd100, 8'd110), '0, '0));
      apply(1'b0, 8'd80,  a_nom, 4'b0001, ex3(rgb(8'd100, 8'd110, 8'd120), '0, '0));

      // Random vectors against the reference blend, all four weights
      for (int n = 0; n < 10000; n++) begin
         pix_t d;
         rgb_t a;
         exp_t e;
         d = pix_t'($urandom_range(0, 255));
         for (int c = 0; c < 3; c++) a[c] = pix_t'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0) d = 8'd0;
         if ($urandom_range(0, 15) == 0) d = 8'd255;
         for (int i = 0; i < 4; i++)
            for (int c = 0; c < 3; c++)
               e[i][c] = ref_ale(LAMS[i], d, a[c]);
         apply(1'b0, d, a, 4'b1111, e);
      end

      apply(1'b0, 8'd0, '0, 4'b0000, '0);
      apply(1'b0, 8'd0, '0, 4'b0000, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_local_ale

// File: doc/local_ale.md
LOCAL_ALE -- requirements
Module: local_ale

Interface
REQ-001 SHALL have parameter LAMBDA, default 128, meaning the 9-bit blend weight (range 0..256, units of 1/256) given to the clipped dark-channel term.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port IDark_dash, input, 8 bits: the refined dark-channel value D of the current pixel, unsigned.
REQ-005 SHALL have ports AR_global, AG_global and AB_global, input, 8 bits each: the global atmospheric light per colour channel, unsigned.
REQ-006 SHALL have ports AR_local, AG_local and AB_local, output, 8 bits each: the local atmospheric light per colour channel, registered.

Function
REQ-007 SHALL compute, for each channel c in {R,G,B}, Mc = min(D, Ac_global) as an 8-bit value.
REQ-008 SHALL compute Ac_local = floor(((256 - LAMBDA) * Ac_global + LAMBDA * Mc) / 256).
REQ-009 SHALL form each product at 17 bits and the sum at 17 bits, then truncate with a right shift of 8; the result is always 255 or less, so no saturation logic exists.
REQ-010 SHALL guarantee Ac_local <= Ac_global for every input combination.
REQ-011 SHALL use a 2-stage pipeline:
- stage 1 registers Mc and Ac_global for all three channels;
- stage 2 registers Ac_local.
REQ-012 SHALL make inputs sampled at rising edge N appear on the outputs after rising edge N+1 (latency 2 clocks).
REQ-013 SHALL accept a new input set every cycle (throughput 1/clock), with no handshake and no stall.
REQ-014 SHALL process the three channels independently and in lockstep; all three outputs update on the same edge.
REQ-015 SHALL handle the boundaries as follows:
- D >= Ac_global: Mc = Ac_global and the output equals Ac_global exactly;
- LAMBDA = 0: output = Ac_global;
- LAMBDA = 256: output = Mc;
- D = 0: output = floor((256 - LAMBDA) * Ac_global / 256).
REQ-016 SHALL allow the global inputs to change on any cycle; each output uses the global value sampled on the same edge as its D.

Reset
REQ-017 SHALL clear all stage-1 and stage-2 registers to 0 on any rising edge where rst = 1, so all outputs read 0 on the edge after rst is sampled high.
REQ-018 SHALL make reset take priority over data: asserting rst mid-stream discards in-flight results.
REQ-019 SHALL, after rst deasserts, output 0 for the first clock edge, with the first valid result appearing 2 edges after the first sample.
REQ-020 SHALL have no asynchronous reset path.

Structure
REQ-021 SHALL define the following in shared package local_ale_pkg:
- PIX_W = 8;
- W_W = 9 (the weight width);
- LAMBDA_DEFAULT = 128;
- pixel type pix_t (8-bit unsigned).
REQ-022 SHALL implement one sub-module, ale_channel, instantiated three times (R, G, B). It SHALL contain the min function, the blend and both pipeline registers for one channel, and take LAMBDA as a parameter.
REQ-023 SHALL contain no other state than the pipeline registers.

Verification
REQ-024 SHALL verify reset: with rst = 1 for 2 edges and any inputs, all outputs read 0; after release with constant inputs, the first valid result appears 2 edges later.
REQ-025 SHALL verify the nominal case: LAMBDA = 128, A_global = (120, 140, 160), D = 150 gives (120, 140, 155) 2 clocks later.
REQ-026 SHALL verify a stream that changes D every 20 ns clock. With A_global held at (120, 140, 160), D = 100, 180, 60, 80 SHALL give, in order, each exactly 2 cycles after its input:
- D = 100: (110, 120, 130);
- D = 180: (120, 140, 160);
- D = 60: (90, 100, 110);
- D = 80: (100, 110, 120).
REQ-027 SHALL verify the extremes:
- LAMBDA = 0, D = 50, A = (200, 10, 255): output (200, 10, 255);
- LAMBDA = 256, same inputs: output (50, 10, 50);
- LAMBDA = 128, D = 255, A = (255, 255, 255): output (255, 255, 255);
- LAMBDA = 128, D = 0, A = (255, 1, 0): output (127, 0, 0).
REQ-028 SHALL verify reset mid-stream: asserting rst for 1 cycle between two valid inputs gives 0 outputs for the flushed slots, followed by the correct result for the next input.
REQ-029 SHALL verify with a randomized self-check of 10,000 random (D, A, LAMBDA) vectors against the REQ-008 reference model with a 2-cycle delay, confirming Ac_local <= Ac_global on every vector.
